// File: rtl/sdr_arb_if.sv
// sdr_arb_if: handshake bundle between the SDRAM scheduler/arbiter and the
// write, read and auto-refresh engines it serves.
//   master : the arbiter (takes requests/done pulses, drives grants/status)
//   slave  : the engine side (drives requests/done pulses, sees grants)
interface sdr_arb_if;
  logic       init_done;
  logic       wr_req;
  logic       rd_req;
  logic       wr_done;
  logic       rd_done;
  logic       ref_done;
  logic       wr_grant;
  logic       rd_grant;
  logic       ref_grant;
  logic       busy;
  logic [2:0] ref_pend;
  logic       ref_ovf;
  logic       err_timeout;

  modport master (
    input  init_done, wr_req, rd_req, wr_done, rd_done, ref_done,
    output wr_grant, rd_grant, ref_grant, busy, ref_pend, ref_ovf, err_timeout
  );

  modport slave (
    output init_done, wr_req, rd_req, wr_done, rd_done, ref_done,
    input  wr_grant, rd_grant, ref_grant, busy, ref_pend, ref_ovf, err_timeout
  );
endinterface

// File: rtl/sdr_arb.sv
// sdr_arb: scheduler/arbiter in front of the SDRAM write, read and
// auto-refresh engines. Waits for power-up init, generates periodic refresh
// demand, and grants the command/DQ bus to exactly one engine at a time,
// holding the grant until that engine reports done.
//
// Optional build macro: SDR_ARB_TIMEOUT_EN
//   defined   : 10-bit per-operation watchdog; on expiry the operation is
//               abandoned, the grant drops and err_timeout sets (sticky).
//   undefined : no watchdog; err_timeout is tied to 0.
module sdr_arb #(
  parameter int REF_PERIOD   = 1250, // cycles between refresh ticks
  parameter int REF_PEND_MAX = 4,    // postponed refreshes before urgency (1..7)
  parameter int STARVE_MAX   = 16    // write grants allowed over a waiting read (1..255)
) (
  input logic        clk,
  input logic        rst,
  sdr_arb_if.master  bus
);

  localparam int          TW         = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_PERIOD - 1);
  localparam logic [2:0]  PEND_MAX   = 3'(REF_PEND_MAX);
  localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_WRITE     = 3'd2,
    S_READ      = 3'd3,
    S_REFRESH   = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [TW-1:0]   timer_r;
  logic [2:0]      ref_pend_r;
  logic            ref_ovf_r;
  logic [7:0]      starve_r;
  logic            wr_grant_r;
  logic            rd_grant_r;
  logic            ref_grant_r;
  logic            busy_r;

  logic            in_op_s;
  logic            tick_s;
  logic            done_s;
  logic            wd_fire_s;
  logic            ref_served_s;
  logic            forced_rd_s;

  assign in_op_s = (state_r == S_WRITE) || (state_r == S_READ) ||
                   (state_r == S_REFRESH);

  // The refresh timer only runs once init is complete; its wrap is the tick.
  assign tick_s = (state_r != S_WAIT_INIT) && (timer_r == TIMER_LAST);

  // A refresh that completes (or is abandoned by the watchdog) pays back one
  // owed refresh; the non-zero guard keeps the count from underflowing.
  assign ref_served_s = (state_r == S_REFRESH) && (bus.ref_done || wd_fire_s) &&
                        (ref_pend_r != 3'd0);

  // Reads have waited through too many writes: the next pick must be a read.
  assign forced_rd_s = (starve_r >= STARVE_LIM) && bus.rd_req;

  // Select the done pulse that belongs to the operation in progress.
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      S_WRITE:   done_s = bus.wr_done;
      S_READ:    done_s = bus.rd_done;
      S_REFRESH: done_s = bus.ref_done;
      default:   done_s = 1'b0;
    endcase
  end

`ifdef SDR_ARB_TIMEOUT_EN
  logic [9:0] wd_r;
  logic       err_timeout_r;

  assign wd_fire_s = in_op_s && (wd_r == 10'd1023) && !done_s;

  // Watchdog: idle between operations keeps it at zero, so every operation
  // starts from zero and counts one per cycle spent in it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= 10'd0;
    end else if (in_op_s && (wd_r != 10'd1023)) begin
      wd_r <= wd_r + 10'd1;
    end else if (in_op_s) begin
      wd_r <= wd_r;
    end else begin
      wd_r <= 10'd0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout_r <= 1'b0;
    end else if (wd_fire_s) begin
      err_timeout_r <= 1'b1;
    end else begin
      err_timeout_r <= err_timeout_r;
    end
  end

  assign bus.err_timeout = err_timeout_r;
`else
  assign wd_fire_s       = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // Next-state decision: init wait, idle priority pick, hold until done.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_WAIT_INIT: begin
        if (bus.init_done) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_INIT;
        end
      end
      S_IDLE: begin
        if (ref_pend_r == PEND_MAX) begin
          state_s = S_REFRESH;
        end else if (bus.wr_req && !forced_rd_s) begin
          state_s = S_WRITE;
        end else if (bus.rd_req) begin
          state_s = S_READ;
        end else if (ref_pend_r != 3'd0) begin
          state_s = S_REFRESH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WRITE, S_READ, S_REFRESH: begin
        if (done_s || wd_fire_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = S_WAIT_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_WAIT_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant flops decode the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_grant_r  <= 1'b0;
      rd_grant_r  <= 1'b0;
      ref_grant_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      wr_grant_r  <= (state_s == S_WRITE);
      rd_grant_r  <= (state_s == S_READ);
      ref_grant_r <= (state_s == S_REFRESH);
      busy_r      <= (state_s == S_WRITE) || (state_s == S_READ) ||
                     (state_s == S_REFRESH);
    end
  end

  // Refresh interval timer, 0..REF_PERIOD-1, held at zero until init is done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= '0;
    end else if (state_r == S_WAIT_INIT) begin
      timer_r <= '0;
    end else if (tick_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Owed-refresh count: tick adds, served refresh subtracts, both cancel;
  // a tick that cannot be recorded at saturation is flagged as lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_pend_r <= 3'd0;
      ref_ovf_r  <= 1'b0;
    end else if (tick_s && ref_served_s) begin
      ref_pend_r <= ref_pend_r;
      ref_ovf_r  <= ref_ovf_r;
    end else if (tick_s && (ref_pend_r == PEND_MAX)) begin
      ref_pend_r <= ref_pend_r;
      ref_ovf_r  <= 1'b1;
    end else if (tick_s) begin
      ref_pend_r <= ref_pend_r + 3'd1;
      ref_ovf_r  <= ref_ovf_r;
    end else if (ref_served_s) begin
      ref_pend_r <= ref_pend_r - 3'd1;
      ref_ovf_r  <= ref_ovf_r;
    end else begin
      ref_pend_r <= ref_pend_r;
      ref_ovf_r  <= ref_ovf_r;
    end
  end

  // Read-starvation count: writes chosen over a waiting read add one,
  // a granted read clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= 8'd0;
    end else if ((state_r == S_IDLE) && (state_s == S_READ)) begin
      starve_r <= 8'd0;
    end else if ((state_r == S_IDLE) && (state_s == S_WRITE) && bus.rd_req &&
                 (starve_r != 8'hFF)) begin
      starve_r <= starve_r + 8'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  assign bus.wr_grant  = wr_grant_r;
  assign bus.rd_grant  = rd_grant_r;
  assign bus.ref_grant = ref_grant_r;
  assign bus.busy      = busy_r;
  assign bus.ref_pend  = ref_pend_r;
  assign bus.ref_ovf   = ref_ovf_r;

endmodule

// File: tb/tb_sdr_arb.sv
// tb_sdr_arb: directed + randomized bench for sdr_arb. A behavioural model
// tracks which engine owns the bus, refreshes owed and the starvation tally,
// and every cycle the DUT outputs are compared against it, alongside
// directed checks of the latency, priority, starvation, urgency, overflow
// and watchdog scenarios.
module tb_sdr_arb;
  localparam int P  = 1250;
  localparam int PM = 4;
  localparam int SM = 16;
  localparam int NONE = 0, WR = 1, RD = 2, RF = 3;
`ifdef SDR_ARB_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sdr_arb_if bus ();

  sdr_arb #(.REF_PERIOD(P), .REF_PEND_MAX(PM), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  // behavioural model
  bit m_init, m_ovf, m_err;
  int m_owner, m_pend, m_starve, m_cyc, m_opcyc, m_ticks;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
    m_owner = NONE; m_pend = 0; m_starve = 0; m_cyc = 0; m_opcyc = 0;
  endtask

  function automatic bit tick_next();
    return m_init && ((m_cyc % P) == P - 1);
  endfunction

  // What the block must do at the coming clock edge given these inputs.
  task automatic model_step(input bit i, input bit w, input bit r,
                            input bit wd, input bit rdd, input bit rfd);
    bit tick, done_ok, fire, served;
    int old_pend;
    if (!m_init) begin
      if (i) begin
        m_init = 1'b1;
        m_cyc  = 0;
      end
      return;
    end
    tick = tick_next();
    m_cyc++;
    if (tick) m_ticks++;
    done_ok = (m_owner == WR && wd) || (m_owner == RD && rdd) || (m_owner == RF && rfd);
    fire    = WD_EN && (m_owner != NONE) && !done_ok && (m_opcyc == 1023);
    served  = (m_owner == RF) && (rfd || fire) && (m_pend > 0);
    old_pend = m_pend;
    if (tick && served) begin
      m_pend = m_pend;
    end else if (tick) begin
      if (m_pend == PM) m_ovf = 1'b1;
      else m_pend++;
    end else if (served) begin
      m_pend--;
    end
    if (m_owner == NONE) begin
      if (old_pend == PM) m_owner = RF;
      else if (w && !(m_starve >= SM && r)) begin
        m_owner = WR;
        if (r) m_starve++;
      end else if (r) begin
        m_owner = RD;
        m_starve = 0;
      end else if (old_pend != 0) m_owner = RF;
      m_opcyc = 0;
    end else if (done_ok || fire) begin
      m_owner = NONE;
      if (fire) m_err = 1'b1;
    end else begin
      m_opcyc++;
    end
  endtask

  function automatic logic [8:0] model_vec();
    return {m_owner == WR, m_owner == RD, m_owner == RF, m_owner != NONE,
            3'(m_pend), m_ovf, m_err};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.wr_grant, bus.rd_grant, bus.ref_grant, bus.busy,
            bus.ref_pend, bus.ref_ovf, bus.err_timeout};
  endfunction

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input bit i, input bit w, input bit r,
                      input bit wd, input bit rdd, input bit rfd);
    bus.init_done = i; bus.wr_req = w; bus.rd_req = r;
    bus.wr_done = wd; bus.rd_done = rdd; bus.ref_done = rfd;
    if (rst) model_reset();
    else model_step(i, w, r, wd, rdd, rfd);
    @(posedge clk);
    #1;
    chk("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  // Engines answer with done once they have held the bus for lat cycles.
  task automatic eng(input bit w, input bit r, input int lat, input bit rf_ok);
    bit wd, rdd, rfd;
    wd  = (m_owner == WR) && (m_opcyc >= lat - 1);
    rdd = (m_owner == RD) && (m_opcyc >= lat - 1);
    rfd = rf_ok && (m_owner == RF) && (m_opcyc >= lat - 1);
    step(1'($urandom_range(0, 1)), w, r, wd, rdd, rfd);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(m_pend == 0 && m_owner == NONE) && n < 200) begin
      eng(1'b0, 1'b0, 2, 1'b1);
      n++;
    end
    chk("drain_budget", 32'(m_pend == 0 && m_owner == NONE), 32'd1);
  endtask

  initial begin
    int n, t0, seen, cnt, first_rd, second_rd;
    bit pw, pr, pf;
    int seq[$];
    checks = 0; errors = 0; m_ticks = 0;
    rst = 1'b1;
    model_reset();
    // reset and init
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_init_quiet", 32'(dut_vec()), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (P - 1) eng(1'b0, 1'b0, 3, 1'b1);
    chk("pend_before_tick", 32'(bus.ref_pend), 32'd0);
    eng(1'b0, 1'b0, 3, 1'b1);
    chk("first_tick_pend", 32'(bus.ref_pend), 32'd1);
    chk("first_tick_no_grant", 32'(bus.ref_grant), 32'd0);
    eng(1'b0, 1'b0, 3, 1'b1);
    chk("refresh_granted", 32'(bus.ref_grant), 32'd1);
    drain();

    // write priority, release latency, idle gap
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr_first", 32'({bus.wr_grant, bus.rd_grant}), 32'd2);
    repeat (19) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr_held", 32'(bus.wr_grant), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wr_release_gap", 32'(bus.busy), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd_after_gap", 32'(bus.rd_grant), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // starvation: 16 writes then a forced read, twice
    pw = 1'b0; pr = 1'b0; n = 0;
    while (seq.size() < 34 && n < 600) begin
      eng(1'b1, 1'b1, 5, 1'b1);
      if (bus.wr_grant && !pw) seq.push_back(WR);
      if (bus.rd_grant && !pr) seq.push_back(RD);
      pw = bus.wr_grant; pr = bus.rd_grant; n++;
    end
    first_rd = -1; second_rd = -1;
    foreach (seq[k]) begin
      if (seq[k] == RD && first_rd < 0) first_rd = k;
      else if (seq[k] == RD && second_rd < 0) second_rd = k;
    end
    chk("starve_first_rd", 32'(first_rd), 32'd16);
    chk("starve_cleared", 32'(second_rd - first_rd - 1), 32'd16);
    drain();

    // refresh urgency under continuous writes
    seen = 0; n = 0;
    while (m_pend < PM && n < 6000) begin
      eng(1'b1, 1'b0, $urandom_range(2, 8), 1'b1);
      if (bus.ref_grant) seen++;
      n++;
    end
    chk("no_early_refresh", 32'(seen), 32'd0);
    n = 0;
    while (!bus.ref_grant && n < 20) begin
      eng(1'b1, 1'b0, $urandom_range(2, 8), 1'b1);
      n++;
    end
    chk("urgent_grant", 32'(bus.ref_grant), 32'd1);
    chk("urgent_pend", 32'(bus.ref_pend), 32'd4);
    t0 = m_ticks; cnt = 1; pf = 1'b1; n = 0;
    while (!(m_pend == 0 && m_owner == NONE) && n < 100) begin
      eng(1'b0, 1'b0, 3, 1'b1);
      if (bus.ref_grant && !pf) cnt++;
      pf = bus.ref_grant; n++;
    end
    chk("urgent_refresh_count", 32'(cnt), 32'(4 + m_ticks - t0));
    chk("urgent_pend_zero", 32'(bus.ref_pend), 32'd0);
    chk("urgent_no_ovf", 32'(bus.ref_ovf), 32'd0);

    // watchdog
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_wr_grant", 32'(bus.wr_grant), 32'd1);
    cnt = 0; n = 0;
    while (bus.wr_grant && n < 1100) begin
      cnt++;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
`ifdef SDR_ARB_TIMEOUT_EN
    chk("wd_drop_cycle", 32'(cnt), 32'd1024);
    chk("wd_err", 32'(bus.err_timeout), 32'd1);
`else
    chk("no_wd_held", 32'(bus.wr_grant), 32'd1);
    chk("no_wd_err", 32'(bus.err_timeout), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    drain();

    // refresh held without done: saturation, overflow, tick+done
    n = 0;
    while (!bus.ref_grant && n < P + 20) begin
      eng(1'b0, 1'b0, 3, 1'b0);
      n++;
    end
    t0 = m_ticks; n = 0;
    while (m_ticks - t0 < 5 && n < 5 * P + 20) begin
      eng(1'b0, 1'b0, 3, 1'b0);
      n++;
    end
`ifndef SDR_ARB_TIMEOUT_EN
    chk("sat_pend", 32'(bus.ref_pend), 32'd4);
    chk("sat_ovf", 32'(bus.ref_ovf), 32'd1);
    chk("sat_grant_held", 32'(bus.ref_grant), 32'd1);
`endif
    n = 0;
    while (!tick_next() && n < P + 5) begin
      eng(1'b0, 1'b0, 3, 1'b0);
      n++;
    end
    pf = (m_owner == RF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifndef SDR_ARB_TIMEOUT_EN
    chk("tick_and_done_pend", 32'(bus.ref_pend), 32'd4);
    chk("tick_and_done_release", 32'(bus.ref_grant), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resat_urgent", 32'(bus.ref_grant), 32'd1);
`endif
    drain();

    // random soak against the model
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
